// File: rtl/ram_burst_ctrl_if.sv
// Command, write-stream, read-stream, status and RAM-port signals of ram_burst_ctrl.
// The slave modport is the controller; the master modport is the datapath/RAM side.
interface ram_burst_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int LW = 7
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;

  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;

  logic          busy;
  logic          done;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output rd_ready,
    output ram_dout,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
    input  ram_we, ram_addr, ram_din
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  rd_ready,
    input  ram_dout,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
    output ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous RAM with a 1-cycle registered read:
// one command at a time, write bytes from a valid/ready stream, read bytes onto one.
module ram_burst_ctrl #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int LW = 7
) (
  input logic            clk,
  input logic            rst,
  ram_burst_ctrl_if.slave io_bus
);
  // state      | meaning
  // S_IDLE     | waiting for a command, cmd_ready high
  // S_WR       | one RAM write per cycle with wr_valid
  // S_RD_ISSUE | address presented with we=0, RAM latches the byte
  // S_RD_CAP   | RAM output captured into rd_data, address advances
  // S_RD_OUT   | rd_data offered and held until rd_ready
  // S_DONE     | single-cycle done pulse, busy still high
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_CAP,
    S_RD_OUT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [LW-1:0] r_remain;
  logic [LW-1:0] w_remain_nxt;
  logic          r_dir;
  logic          w_dir_nxt;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] w_rd_data_nxt;
  logic          w_wr_beat;

  assign w_wr_beat = (r_state == S_WR) && io_bus.wr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_dir     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_remain  <= w_remain_nxt;
      r_dir     <= w_dir_nxt;
      r_rd_data <= w_rd_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_remain_nxt  = r_remain;
    w_dir_nxt     = r_dir;
    w_rd_data_nxt = r_rd_data;
    case (r_state)
      S_IDLE: begin
        if (io_bus.cmd_valid) begin
          w_addr_nxt   = io_bus.cmd_addr;
          w_remain_nxt = io_bus.cmd_len;
          w_dir_nxt    = io_bus.cmd_wr;
          if (io_bus.cmd_len == '0) begin
            w_state_nxt = S_DONE;
          end else if (io_bus.cmd_wr) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD_ISSUE;
          end
        end
      end
      S_WR: begin
        if (io_bus.wr_valid) begin
          w_addr_nxt   = r_addr + AW'(1);
          w_remain_nxt = r_remain - LW'(1);
          if (r_remain == LW'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RD_ISSUE: begin
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        // Address and count advance here so RD_OUT can hold a stable address.
        w_rd_data_nxt = io_bus.ram_dout;
        w_addr_nxt    = r_addr + AW'(1);
        w_remain_nxt  = r_remain - LW'(1);
        w_state_nxt   = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (io_bus.rd_ready) begin
          w_state_nxt = (r_remain == '0) ? S_DONE : S_RD_ISSUE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign io_bus.cmd_ready = (r_state == S_IDLE);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.wr_ready  = (r_state == S_WR);
  assign io_bus.rd_valid  = (r_state == S_RD_OUT);
  assign io_bus.done      = (r_state == S_DONE);
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.ram_we    = w_wr_beat;
  assign io_bus.ram_addr  = r_addr;
  assign io_bus.ram_din   = io_bus.wr_data;

  a_we_only_in_write: assert property (@(posedge clk) disable iff (rst)
    io_bus.ram_we |-> (r_state == S_WR) && r_dir);

  a_read_states_dir: assert property (@(posedge clk) disable iff (rst)
    (r_state inside {S_RD_ISSUE, S_RD_CAP, S_RD_OUT}) |-> !r_dir);

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    io_bus.done |=> !io_bus.done);

  a_rd_hold: assert property (@(posedge clk) disable iff (rst)
    (io_bus.rd_valid && !io_bus.rd_ready) |=> (io_bus.rd_valid && $stable(io_bus.rd_data)));
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: a RAM model, an address/data reference memory
// with expected-transfer queues, a per-cycle compare process and literal timing checks.
module tb_ram_burst_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_burst_ctrl_if #(.AW(AW), .DW(DW), .LW(LW)) bus_if ();

  ram_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus_if)
  );

  // 64x8 single-port RAM with registered read whenever we=0
  logic [7:0] ram_mem [64];
  always @(posedge clk) begin
    if (bus_if.ram_we) ram_mem[bus_if.ram_addr] <= bus_if.ram_din;
    else               bus_if.ram_dout <= ram_mem[bus_if.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: memory image plus queues of the transfers each command must produce
  logic [7:0] ref_mem [64];
  int exp_wa[$];
  int exp_wd[$];
  int exp_rd[$];

  int wr_rel[$];
  int rv_rel[$];
  int rd_log[$];
  int done_rel = -1;
  int cr_rel   = -1;
  int n_done   = 0;
  int acc      = 0;

  int lit[$];
  int dq[$];
  int pq[$];
  int n0;

  bit         rv_prev = 1'b0;
  bit         rr_prev = 1'b0;
  bit         cr_prev = 1'b1;
  logic [7:0] held_d;
  logic [5:0] held_a;

  function automatic void chk_eq(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void chk_q(string nm, int got[$], int exp[$]);
    int a;
    int e;
    a = got.size();
    e = exp.size();
    if (a == e) begin
      for (int k = 0; k < got.size(); k++) begin
        if (got[k] != exp[k]) begin
          a = got[k];
          e = exp[k];
          break;
        end
      end
    end
    chk_eq(nm, a, e);
  endfunction

  // Per-cycle compare, sampled on the falling edge; rel counts cycles from accept (1 = first)
  always @(negedge clk) begin
    int rel;
    if (rst) begin
      rv_prev = 1'b0;
      rr_prev = 1'b0;
      cr_prev = 1'b1;
    end else begin
      rel = cyc - acc + 1;
      chk_eq("ready_vs_busy", int'(bus_if.cmd_ready), int'(!bus_if.busy));
      if (bus_if.ram_we) begin
        wr_rel.push_back(rel);
        if (exp_wa.size() == 0) begin
          chk_eq("unexpected_write", int'(bus_if.ram_addr), -1);
        end else begin
          chk_eq("wr_addr", int'(bus_if.ram_addr), exp_wa.pop_front());
          chk_eq("wr_data", int'(bus_if.ram_din), exp_wd.pop_front());
        end
      end
      if (bus_if.rd_valid) begin
        if (!rv_prev) rv_rel.push_back(rel);
        if (rv_prev && !rr_prev) begin
          chk_eq("rd_hold_data", int'(bus_if.rd_data), int'(held_d));
          chk_eq("rd_hold_addr", int'(bus_if.ram_addr), int'(held_a));
        end
        if (bus_if.rd_ready) begin
          rd_log.push_back(int'(bus_if.rd_data));
          if (exp_rd.size() == 0) chk_eq("unexpected_read", int'(bus_if.rd_data), -1);
          else                    chk_eq("rd_data", int'(bus_if.rd_data), exp_rd.pop_front());
        end
      end
      if (bus_if.done) begin
        n_done++;
        done_rel = rel;
        chk_eq("done_busy", int'(bus_if.busy), 1);
      end
      if (bus_if.cmd_ready && !cr_prev) cr_rel = rel;
      rv_prev = bus_if.rd_valid;
      rr_prev = bus_if.rd_ready;
      held_d  = bus_if.rd_data;
      held_a  = bus_if.ram_addr;
      cr_prev = bus_if.cmd_ready;
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(bit wr, int a, int l);
    int t;
    t = 0;
    bus_if.cmd_wr    = wr;
    bus_if.cmd_addr  = 6'(a);
    bus_if.cmd_len   = 7'(l);
    bus_if.cmd_valid = 1'b1;
    while (!bus_if.cmd_ready && t < 20) begin
      wait_cycle();
      t++;
    end
    chk_eq("cmd_ready_timeout", int'(t < 20), 1);
    wait_cycle();
    acc = cyc;
    bus_if.cmd_valid = 1'b0;
    wr_rel.delete();
    rv_rel.delete();
    rd_log.delete();
    done_rel = -1;
    cr_rel   = -1;
  endtask

  task automatic write_burst(int a, int l, int data[$], int pat[$]);
    int i;
    int p;
    int t;
    bit hs;
    i = 0; p = 0; t = 0; hs = 1'b0;
    for (int k = 0; k < l; k++) begin
      exp_wa.push_back((a + k) % 64);
      exp_wd.push_back(data[k]);
      ref_mem[(a + k) % 64] = 8'(data[k]);
    end
    send_cmd(1'b1, a, l);
    while (t < 200) begin
      if (hs) i++;
      if (bus_if.done) break;
      chk_eq("wr_ready_high", int'(bus_if.wr_ready), 1);
      bus_if.wr_valid = (i < l) && (pat[p % pat.size()] != 0);
      bus_if.wr_data  = (i < l) ? 8'(data[i]) : 8'h00;
      hs = bus_if.wr_valid && bus_if.wr_ready;
      p++;
      wait_cycle();
      t++;
    end
    bus_if.wr_valid = 1'b0;
    chk_eq("wr_done_timeout", int'(t < 200), 1);
    wait_cycle();
    wait_cycle();
    chk_eq("wr_queue_drained", exp_wa.size(), 0);
  endtask

  task automatic read_burst(int a, int l, int stall_at, int stall_len);
    int nacc;
    int st;
    int t;
    bit hs;
    nacc = 0; st = 0; t = 0; hs = 1'b0;
    for (int k = 0; k < l; k++) exp_rd.push_back(int'(ref_mem[(a + k) % 64]));
    send_cmd(1'b0, a, l);
    while (t < 300) begin
      if (hs) nacc++;
      if (bus_if.done) break;
      if (bus_if.rd_valid && nacc == stall_at && st < stall_len) begin
        bus_if.rd_ready = 1'b0;
        st++;
      end else begin
        bus_if.rd_ready = 1'b1;
      end
      hs = bus_if.rd_valid && bus_if.rd_ready;
      wait_cycle();
      t++;
    end
    bus_if.rd_ready = 1'b1;
    chk_eq("rd_done_timeout", int'(t < 300), 1);
    chk_eq("rd_accept_count", nacc, l);
    wait_cycle();
    wait_cycle();
    chk_eq("rd_queue_drained", exp_rd.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int k = 0; k < 64; k++) begin
      ram_mem[k] = 8'h00;
      ref_mem[k] = 8'h00;
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.wr_data   = '0;
    bus_if.wr_valid  = 1'b0;
    bus_if.rd_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_cmd_ready", int'(bus_if.cmd_ready), 1);
    chk_eq("rst_busy", int'(bus_if.busy), 0);
    chk_eq("rst_done", int'(bus_if.done), 0);
    chk_eq("rst_rd_valid", int'(bus_if.rd_valid), 0);
    chk_eq("rst_wr_ready", int'(bus_if.wr_ready), 0);
    chk_eq("rst_ram_we", int'(bus_if.ram_we), 0);
    chk_eq("rst_ram_addr", int'(bus_if.ram_addr), 0);
    chk_eq("rst_rd_data", int'(bus_if.rd_data), 0);
    rst = 1'b0;
    wait_cycle();

    // Write wrapping 63 -> 0, wr_valid held high
    n0 = n_done;
    dq = '{'hA1, 'hA2, 'hA3, 'hA4};
    pq = '{1};
    write_burst(62, 4, dq, pq);
    lit = '{1, 2, 3, 4};
    chk_q("t1_write_cycles", wr_rel, lit);
    chk_eq("t1_done_cycle", done_rel, 5);
    chk_eq("t1_ready_cycle", cr_rel, 6);
    chk_eq("t1_done_count", n_done - n0, 1);

    // Read back the same four bytes with rd_ready high
    n0 = n_done;
    read_burst(62, 4, -1, 0);
    lit = '{3, 6, 9, 12};
    chk_q("t2_valid_cycles", rv_rel, lit);
    lit = '{'hA1, 'hA2, 'hA3, 'hA4};
    chk_q("t2_read_bytes", rd_log, lit);
    chk_eq("t2_done_cycle", done_rel, 13);
    chk_eq("t2_write_count", wr_rel.size(), 0);
    chk_eq("t2_done_count", n_done - n0, 1);

    // Backpressure: second byte held for 5 cycles
    n0 = n_done;
    read_burst(62, 4, 1, 5);
    lit = '{3, 6, 14, 17};
    chk_q("t3_valid_cycles", rv_rel, lit);
    lit = '{'hA1, 'hA2, 'hA3, 'hA4};
    chk_q("t3_read_bytes", rd_log, lit);
    chk_eq("t3_done_cycle", done_rel, 18);
    chk_eq("t3_done_count", n_done - n0, 1);

    // Write with gaps in wr_valid
    n0 = n_done;
    dq = '{'hC0, 'hC1, 'hC2};
    pq = '{1, 0, 0, 1, 1};
    write_burst(32, 3, dq, pq);
    lit = '{1, 4, 5};
    chk_q("t4_write_cycles", wr_rel, lit);
    chk_eq("t4_done_cycle", done_rel, 6);
    chk_eq("t4_done_count", n_done - n0, 1);

    // Zero-length command, then a command offered while busy
    n0 = n_done;
    send_cmd(1'b1, 5, 0);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_len   = 7'd1;
    chk_eq("t5_done_now", int'(bus_if.done), 1);
    chk_eq("t5_not_ready", int'(bus_if.cmd_ready), 0);
    wait_cycle();
    bus_if.cmd_valid = 1'b0;
    chk_eq("t5_idle_busy", int'(bus_if.busy), 0);
    chk_eq("t5_idle_done", int'(bus_if.done), 0);
    wait_cycle();
    chk_eq("t5_not_queued", int'(bus_if.busy), 0);
    chk_eq("t5_done_cycle", done_rel, 1);
    chk_eq("t5_done_count", n_done - n0, 1);
    chk_eq("t5_no_writes", wr_rel.size(), 0);
    chk_eq("t5_no_reads", rv_rel.size(), 0);

    // Reset after two bytes of an 8-byte write
    n0 = n_done;
    for (int k = 0; k < 2; k++) begin
      exp_wa.push_back(16 + k);
      exp_wd.push_back('hB0 + k);
      ref_mem[16 + k] = 8'('hB0 + k);
    end
    send_cmd(1'b1, 16, 8);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_data  = 8'hB0;
    wait_cycle();
    bus_if.wr_data  = 8'hB1;
    wait_cycle();
    bus_if.wr_data  = 8'hB2;
    rst = 1'b1;
    #1;
    chk_eq("t6_cmd_ready", int'(bus_if.cmd_ready), 1);
    chk_eq("t6_busy", int'(bus_if.busy), 0);
    chk_eq("t6_done", int'(bus_if.done), 0);
    chk_eq("t6_wr_ready", int'(bus_if.wr_ready), 0);
    chk_eq("t6_ram_we", int'(bus_if.ram_we), 0);
    chk_eq("t6_ram_addr", int'(bus_if.ram_addr), 0);
    chk_eq("t6_rd_valid", int'(bus_if.rd_valid), 0);
    lit = '{1, 2};
    chk_q("t6_write_cycles", wr_rel, lit);
    chk_eq("t6_writes_left", exp_wa.size(), 0);
    bus_if.wr_valid = 1'b0;
    wait_cycle();
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
    chk_eq("t6_no_done", n_done - n0, 0);
    read_burst(16, 2, -1, 0);
    lit = '{'hB0, 'hB1};
    chk_q("t6_readback", rd_log, lit);

    // Reset while a read byte is waiting for rd_ready
    n0 = n_done;
    bus_if.rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) exp_rd.push_back(int'(ref_mem[32 + k]));
    send_cmd(1'b0, 32, 3);
    t = 0;
    while (!bus_if.rd_valid && t < 10) begin
      wait_cycle();
      t++;
    end
    chk_eq("t7_valid_timeout", int'(t < 10), 1);
    chk_eq("t7_first_byte", int'(bus_if.rd_data), 'hC0);
    wait_cycle();
    wait_cycle();
    rst = 1'b1;
    #1;
    chk_eq("t7_rd_valid", int'(bus_if.rd_valid), 0);
    chk_eq("t7_rd_data", int'(bus_if.rd_data), 0);
    chk_eq("t7_busy", int'(bus_if.busy), 0);
    exp_rd.delete();
    wait_cycle();
    rst = 1'b0;
    bus_if.rd_ready = 1'b1;
    wait_cycle();
    wait_cycle();
    chk_eq("t7_idle", int'(bus_if.busy), 0);
    chk_eq("t7_no_done", n_done - n0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
